// File: rtl/alu4_ctrl_pkg.sv
// Shared opcodes, flag bit positions, FSM states and command record for the alu4 execution stage.
package alu4_ctrl_pkg;

  localparam logic [2:0] OP_NOTA = 3'b000;
  localparam logic [2:0] OP_NOTB = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  localparam int unsigned FLG_C = 3;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_V = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StExec = 2'd2
  } state_e;

  typedef struct packed {
    logic       ld;
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [3:0] imm;
  } cmd_t;

  function automatic logic [3:0] pack_flags(input logic c, input logic n, input logic z,
                                            input logic v);
    logic [3:0] f;
    f        = '0;
    f[FLG_C] = c;
    f[FLG_N] = n;
    f[FLG_Z] = z;
    f[FLG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu4_ctrl_if.sv
// Command handshake, writeback status and debug read port of the alu4 execution stage.
interface alu4_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_ld;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd;
  logic [1:0] cmd_ra;
  logic [1:0] cmd_rb;
  logic [3:0] cmd_imm;
  logic       done;
  logic [3:0] wb_data;
  logic [3:0] flags;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;

  modport master (
    output cmd_valid, cmd_ld, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm, dbg_addr,
    input  cmd_ready, done, wb_data, flags, dbg_data
  );

  modport slave (
    input  cmd_valid, cmd_ld, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm, dbg_addr,
    output cmd_ready, done, wb_data, flags, dbg_data
  );
endinterface

// File: rtl/alu4.sv
// Combinational 4-bit ALU: eight logic/arithmetic ops with carry, negative, zero, overflow flags.
module alu4
  import alu4_ctrl_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  output logic [3:0] result,
  output logic       c,
  output logic       n,
  output logic       z,
  output logic       v
);

  logic [3:0] b_inv;
  logic [4:0] sum;

  assign b_inv = ~b;

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    sum    = '0;
    case (op)
      OP_NOTA: result = ~a;
      OP_NOTB: result = ~b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[3:0];
        c      = sum[4];
        v      = (a[3] == b[3]) && (sum[3] != a[3]);
      end
      OP_SUB: begin
        // Subtract as A + ~B + 1 so carry means "no borrow".
        sum    = {1'b0, a} + {1'b0, b_inv} + 5'd1;
        result = sum[3:0];
        c      = sum[4];
        v      = (a[3] == b_inv[3]) && (sum[3] != a[3]);
      end
      default: result = '0;
    endcase
  end

  assign n = result[3];
  assign z = (result == 4'd0);

endmodule

// File: rtl/alu4_ctrl.sv
// Three-state execution stage: accept a command, read operands, run alu4 and write back.
module alu4_ctrl
  import alu4_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  alu4_ctrl_if.slave   bus
);

  state_e     state_q;
  cmd_t       cmd_q;
  cmd_t       cmd_in;
  logic [3:0] rf_q [4];
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic       ready_q;
  logic       done_q;
  logic [3:0] wb_q;
  logic [3:0] flags_q;

  logic [3:0] alu_result;
  logic       alu_c;
  logic       alu_n;
  logic       alu_z;
  logic       alu_v;
  logic [3:0] alu_flags;
  logic [3:0] wb_val;

  assign cmd_in = '{
    ld:  bus.cmd_ld,
    op:  bus.cmd_op,
    rd:  bus.cmd_rd,
    ra:  bus.cmd_ra,
    rb:  bus.cmd_rb,
    imm: bus.cmd_imm
  };

  alu4 u_alu4 (
    .a      (a_q),
    .b      (b_q),
    .op     (cmd_q.op),
    .result (alu_result),
    .c      (alu_c),
    .n      (alu_n),
    .z      (alu_z),
    .v      (alu_v)
  );

  assign alu_flags = pack_flags(alu_c, alu_n, alu_z, alu_v);
  // A load carries its immediate through the A operand register.
  assign wb_val    = cmd_q.ld ? a_q : alu_result;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      wb_q    <= '0;
      flags_q <= '0;
      for (int i = 0; i < 4; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            cmd_q   <= cmd_in;
            ready_q <= 1'b0;
            state_q <= StRead;
          end
        end
        StRead: begin
          a_q     <= cmd_q.ld ? cmd_q.imm : rf_q[cmd_q.ra];
          b_q     <= rf_q[cmd_q.rb];
          state_q <= StExec;
        end
        StExec: begin
          rf_q[cmd_q.rd] <= wb_val;
          wb_q           <= wb_val;
          done_q         <= 1'b1;
          if (!cmd_q.ld) begin
            flags_q <= alu_flags;
          end
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.done      = done_q;
  assign bus.wb_data   = wb_q;
  assign bus.flags     = flags_q;
  assign bus.dbg_data  = rf_q[bus.dbg_addr];

endmodule

// File: tb/tb_alu4_ctrl.sv
// Directed bench for alu4_ctrl: loads, arithmetic/logic ops, back-to-back issue and mid-command reset.
module tb_alu4_ctrl;
  import alu4_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu4_ctrl_if bus_if ();

  alu4_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  // Issue one command and wait for done; lat counts rising edges from accept to done.
  task automatic run_cmd(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] ra, input logic [1:0] rb, input logic [3:0] imm,
                         output int lat);
    int w;
    w = 0;
    while (!bus_if.cmd_ready && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (bus_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: cmd_ready=%b required 1", bus_if.cmd_ready);
    end
    bus_if.cmd_ld    = ld;
    bus_if.cmd_op    = op;
    bus_if.cmd_rd    = rd;
    bus_if.cmd_ra    = ra;
    bus_if.cmd_rb    = rb;
    bus_if.cmd_imm   = imm;
    bus_if.dbg_addr  = rd;
    bus_if.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (bus_if.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_ld    = 1'b0;
    bus_if.cmd_op    = '0;
    bus_if.cmd_rd    = '0;
    bus_if.cmd_ra    = '0;
    bus_if.cmd_rb    = '0;
    bus_if.cmd_imm   = '0;
    bus_if.dbg_addr  = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    checks++;
    if (bus_if.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", bus_if.cmd_ready);
    end
    checks++;
    if (bus_if.done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b want 0", bus_if.done);
    end
    checks++;
    if (bus_if.flags !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", bus_if.flags);
    end
    checks++;
    if (bus_if.wb_data !== 4'b0000) begin
      errors++; $display("FAIL reset_wb: got %b want 0000", bus_if.wb_data);
    end
    for (int i = 0; i < 4; i++) begin
      bus_if.dbg_addr = 2'(i);
      #1;
      checks++;
      if (bus_if.dbg_data !== 4'b0000) begin
        errors++; $display("FAIL reset_rf%0d: got %b want 0000", i, bus_if.dbg_data);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat;
    run_cmd(1'b1, OP_NOTA, 2'd0, 2'd0, 2'd0, 4'd7, lat);
    checks++;
    if (lat !== 2 || bus_if.wb_data !== 4'd7) begin
      errors++; $display("FAIL load_r0: lat=%0d wb=%b want lat=2 wb=0111", lat, bus_if.wb_data);
    end
    run_cmd(1'b1, OP_NOTA, 2'd1, 2'd0, 2'd0, 4'd9, lat);
    checks++;
    if (bus_if.dbg_data !== 4'd9) begin
      errors++; $display("FAIL load_r1: dbg=%b want 1001", bus_if.dbg_data);
    end
    run_cmd(1'b0, OP_ADD, 2'd2, 2'd0, 2'd1, 4'd0, lat);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL add_latency: got %0d want 2", lat);
    end
    checks++;
    if (bus_if.wb_data !== 4'b0000 || bus_if.flags !== 4'b1010) begin
      errors++;
      $display("FAIL add_result: wb=%b flags=%b want wb=0000 flags=1010",
               bus_if.wb_data, bus_if.flags);
    end
    checks++;
    if (bus_if.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL ready_with_done: got %b want 1", bus_if.cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus_if.done !== 1'b0) begin
      errors++; $display("FAIL done_pulse: got %b want 0", bus_if.done);
    end
  endtask

  task automatic test_sub();
    int lat;
    run_cmd(1'b0, OP_SUB, 2'd3, 2'd0, 2'd1, 4'd0, lat);
    checks++;
    if (bus_if.wb_data !== 4'b1110 || bus_if.flags !== 4'b0101 || bus_if.dbg_data !== 4'b1110)
    begin
      errors++;
      $display("FAIL sub_result: wb=%b flags=%b dbg=%b want 1110 0101 1110",
               bus_if.wb_data, bus_if.flags, bus_if.dbg_data);
    end
    run_cmd(1'b1, OP_ADD, 2'd2, 2'd0, 2'd0, 4'hc, lat);
    checks++;
    if (bus_if.wb_data !== 4'hc || bus_if.flags !== 4'b0101) begin
      errors++;
      $display("FAIL load_keeps_flags: wb=%b flags=%b want 1100 0101",
               bus_if.wb_data, bus_if.flags);
    end
  endtask

  task automatic test_logic();
    int lat;
    run_cmd(1'b1, OP_NOTA, 2'd0, 2'd0, 2'd0, 4'b0101, lat);
    run_cmd(1'b1, OP_NOTA, 2'd1, 2'd0, 2'd0, 4'b0011, lat);
    run_cmd(1'b0, OP_XOR, 2'd2, 2'd0, 2'd1, 4'd0, lat);
    checks++;
    if (bus_if.wb_data !== 4'b0110 || bus_if.flags !== 4'b0000) begin
      errors++;
      $display("FAIL xor_result: wb=%b flags=%b want 0110 0000", bus_if.wb_data, bus_if.flags);
    end
    run_cmd(1'b0, OP_NOTA, 2'd3, 2'd0, 2'd1, 4'd0, lat);
    checks++;
    if (bus_if.wb_data !== 4'b1010 || bus_if.flags !== 4'b0100) begin
      errors++;
      $display("FAIL nota_result: wb=%b flags=%b want 1010 0100", bus_if.wb_data, bus_if.flags);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    bus_if.cmd_ld    = 1'b0;
    bus_if.cmd_op    = OP_ADD;
    bus_if.cmd_rd    = 2'd2;
    bus_if.cmd_ra    = 2'd0;
    bus_if.cmd_rb    = 2'd1;
    bus_if.dbg_addr  = 2'd2;
    bus_if.cmd_valid = 1'b1;
    @(posedge clk); #1;
    // Second command waits with valid held high while the first is in flight.
    bus_if.cmd_op = OP_AND;
    bus_if.cmd_rd = 2'd3;
    bus_if.cmd_ra = 2'd2;
    bus_if.cmd_rb = 2'd1;
    gap = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (bus_if.done === 1'b1) begin
        gap = i;
        break;
      end
    end
    checks++;
    if (bus_if.wb_data !== 4'b1000 || bus_if.flags !== 4'b0101 || bus_if.dbg_data !== 4'b1000)
    begin
      errors++;
      $display("FAIL b2b_add: wb=%b flags=%b dbg=%b want 1000 0101 1000",
               bus_if.wb_data, bus_if.flags, bus_if.dbg_data);
    end
    @(posedge clk); #1;
    gap++;
    bus_if.cmd_valid = 1'b0;
    bus_if.dbg_addr  = 2'd3;
    checks++;
    if (gap !== 3 || bus_if.cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: gap=%0d ready=%b want gap=3 ready=0", gap, bus_if.cmd_ready);
    end
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (bus_if.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 2 || bus_if.wb_data !== 4'b0000 || bus_if.flags !== 4'b0010 ||
        bus_if.dbg_data !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_and: lat=%0d wb=%b flags=%b dbg=%b want 2 0000 0010 0000",
               lat, bus_if.wb_data, bus_if.flags, bus_if.dbg_data);
    end
  endtask

  task automatic test_alias();
    int lat;
    run_cmd(1'b0, OP_ADD, 2'd1, 2'd1, 2'd1, 4'd0, lat);
    checks++;
    if (bus_if.dbg_data !== 4'b0110 || bus_if.flags !== 4'b0000) begin
      errors++;
      $display("FAIL alias_add: dbg=%b flags=%b want 0110 0000", bus_if.dbg_data, bus_if.flags);
    end
  endtask

  task automatic test_reset_exec();
    int lat;
    bus_if.cmd_ld    = 1'b0;
    bus_if.cmd_op    = OP_ADD;
    bus_if.cmd_rd    = 2'd2;
    bus_if.cmd_ra    = 2'd0;
    bus_if.cmd_rb    = 2'd1;
    bus_if.dbg_addr  = 2'd2;
    bus_if.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus_if.cmd_ready !== 1'b1 || bus_if.flags !== 4'b0000 || bus_if.wb_data !== 4'b0000) begin
      errors++;
      $display("FAIL rst_exec_async: ready=%b flags=%b wb=%b want 1 0000 0000",
               bus_if.cmd_ready, bus_if.flags, bus_if.wb_data);
    end
    @(posedge clk); #1;
    checks++;
    if (bus_if.done !== 1'b0 || bus_if.dbg_data !== 4'b0000) begin
      errors++;
      $display("FAIL rst_exec_nowb: done=%b r2=%b want 0 0000", bus_if.done, bus_if.dbg_data);
    end
    reset_n = 1'b1;
    run_cmd(1'b1, OP_NOTA, 2'd1, 2'd0, 2'd0, 4'd4, lat);
    checks++;
    if (lat !== 2 || bus_if.wb_data !== 4'd4 || bus_if.dbg_data !== 4'd4 ||
        bus_if.flags !== 4'b0000) begin
      errors++;
      $display("FAIL rst_then_load: lat=%0d wb=%b dbg=%b flags=%b want 2 0100 0100 0000",
               lat, bus_if.wb_data, bus_if.dbg_data, bus_if.flags);
    end
    bus_if.dbg_addr = 2'd0;
    #1;
    checks++;
    if (bus_if.dbg_data !== 4'b0000) begin
      errors++; $display("FAIL rst_clears_r0: got %b want 0000", bus_if.dbg_data);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    test_alias();
    test_reset_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
